// File: rtl/mem_responder.sv
// Single-port 64-bit memory responder: one outstanding request, fixed wait latency,
// byte-masked stores, address-range/alignment fault reporting.
module mem_responder #(
    parameter int unsigned DEPTH   = 1024,
    parameter logic [63:0] BASE    = 64'h0000_0000_8000_0000,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [7:0]  req_wmask,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int unsigned IW   = $clog2(DEPTH);
    localparam logic [3:0]  LAT  = LATENCY[3:0];
    localparam logic [63:0] SPAN = 64'(DEPTH) << 3;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            ready_en_q;
    logic            we_q, we_d;
    logic            err_q, err_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [63:0]     wdata_q, wdata_d;
    logic [7:0]      wmask_q, wmask_d;
    logic [63:0]     rdata_q, rdata_d;
    logic            rerr_q, rerr_d;

    logic [63:0]     mem_q [DEPTH];

    logic [63:0]     offset;
    logic            in_fault;
    logic            accept;
    logic            enter_resp;
    logic            cur_we, cur_err;
    logic [IW-1:0]   cur_idx;
    logic [63:0]     cur_wdata;
    logic [7:0]      cur_wmask;

    // Offset compare only matters once addr >= BASE, so BASE+SPAN never has to be formed.
    assign offset   = req_addr - BASE;
    assign in_fault = (req_addr < BASE) || (offset >= SPAN) || (req_addr[2:0] != 3'b000);
    assign accept   = req_valid && req_ready;

    // With zero latency RESP is entered on the accept edge, so the live request is used.
    assign cur_we    = (state_q == IDLE) ? req_we            : we_q;
    assign cur_err   = (state_q == IDLE) ? in_fault          : err_q;
    assign cur_idx   = (state_q == IDLE) ? offset[IW+2:3]    : idx_q;
    assign cur_wdata = (state_q == IDLE) ? req_wdata         : wdata_q;
    assign cur_wmask = (state_q == IDLE) ? req_wmask         : wmask_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            ready_en_q <= 1'b0;
            we_q       <= 1'b0;
            err_q      <= 1'b0;
            idx_q      <= '0;
            wdata_q    <= '0;
            wmask_q    <= '0;
            rdata_q    <= '0;
            rerr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ready_en_q <= 1'b1;
            we_q       <= we_d;
            err_q      <= err_d;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
            wmask_q    <= wmask_d;
            rdata_q    <= rdata_d;
            rerr_q     <= rerr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        err_d      = err_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        wmask_d    = wmask_q;
        rdata_d    = rdata_q;
        rerr_d     = rerr_q;
        enter_resp = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    we_d    = req_we;
                    err_d   = in_fault;
                    idx_d   = offset[IW+2:3];
                    wdata_d = req_wdata;
                    wmask_d = req_wmask;
                    if (LAT == 4'd0) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = LAT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                    rdata_d = '0;
                    rerr_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        if (enter_resp) begin
            rerr_d  = cur_err;
            rdata_d = (cur_we || cur_err) ? '0 : mem_q[cur_idx];
        end
    end

    always_comb begin
        req_ready = (state_q == IDLE) && ready_en_q;
        rsp_valid = (state_q == RESP);
        rsp_rdata = rdata_q;
        rsp_err   = rerr_q;
    end

    always_ff @(posedge clk) begin
        if (enter_resp && cur_we && !cur_err) begin
            for (int unsigned b = 0; b < 8; b++) begin
                if (cur_wmask[b]) mem_q[cur_idx][8*b +: 8] <= cur_wdata[8*b +: 8];
            end
        end
    end
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench: two responders (LATENCY=2 and LATENCY=0) sharing request wiring,
// one selected at a time.
module tb_mem_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [63:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic [7:0]  req_wmask = '0;
    logic        rsp_ready = 1'b0;

    logic        valid_a, valid_b;
    logic        rdy_a, rdy_b, vld_a, vld_b, err_a, err_b;
    logic [63:0] rdata_a, rdata_b;
    logic        o_rdy, o_vld, o_err;
    logic [63:0] o_rdata;

    int checks   = 0;
    int failures = 0;

    assign valid_a = req_valid && !sel;
    assign valid_b = req_valid && sel;

    always_comb begin
        o_rdy   = sel ? rdy_b   : rdy_a;
        o_vld   = sel ? vld_b   : vld_a;
        o_err   = sel ? err_b   : err_a;
        o_rdata = sel ? rdata_b : rdata_a;
    end

    always #5 clk = ~clk;

    mem_responder #(.DEPTH(1024), .BASE(64'h0000_0000_8000_0000), .LATENCY(2)) dut_a (
        .clk(clk), .rst(rst), .req_valid(valid_a), .req_ready(rdy_a), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .rsp_valid(vld_a), .rsp_ready(rsp_ready), .rsp_rdata(rdata_a), .rsp_err(err_a)
    );

    mem_responder #(.DEPTH(1024), .BASE(64'h0000_0000_8000_0000), .LATENCY(0)) dut_b (
        .clk(clk), .rst(rst), .req_valid(valid_b), .req_ready(rdy_b), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .rsp_valid(vld_b), .rsp_ready(rsp_ready), .rsp_rdata(rdata_b), .rsp_err(err_b)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b0;
        #1;
        check({tag, " rst req_ready"}, 64'(o_rdy), 64'd0);
        check({tag, " rst rsp_valid"}, 64'(o_vld), 64'd0);
        check({tag, " rst rsp_err"}, 64'(o_err), 64'd0);
        check({tag, " rst rsp_rdata"}, o_rdata, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check({tag, " ready before edge"}, 64'(o_rdy), 64'd0);
        @(negedge clk);
        check({tag, " ready after edge"}, 64'(o_rdy), 64'd1);
    endtask

    // Presents a request and returns at the negedge following the accept edge.
    task automatic issue(input string tag, input logic we, input logic [63:0] addr,
                         input logic [63:0] wdata, input logic [7:0] mask, input logic keep);
        int n = 0;
        req_we = we; req_addr = addr; req_wdata = wdata; req_wmask = mask;
        req_valid = 1'b1;
        while (!o_rdy && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, " accept"}, 64'(o_rdy), 64'd1);
        @(posedge clk);
        @(negedge clk);
        if (!keep) req_valid = 1'b0;
    endtask

    task automatic wait_vld(output int n);
        n = 1;
        while (!o_vld && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic finish_rsp(input string tag, input logic [63:0] exp_rdata,
                              input logic exp_err, input int hold);
        int n;
        wait_vld(n);
        check({tag, " latency"}, 64'(n), sel ? 64'd1 : 64'd3);
        check({tag, " rdata"}, o_rdata, exp_rdata);
        check({tag, " err"}, 64'(o_err), 64'(exp_err));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, " hold valid"}, 64'(o_vld), 64'd1);
            check({tag, " hold rdata"}, o_rdata, exp_rdata);
            check({tag, " hold req_ready"}, 64'(o_rdy), 64'd0);
        end
        rsp_ready = 1'b1;
        #1;
        check({tag, " ready in handshake"}, 64'(o_rdy), 64'd0);
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        check({tag, " valid after"}, 64'(o_vld), 64'd0);
        check({tag, " ready after"}, 64'(o_rdy), 64'd1);
    endtask

    task automatic txn(input string tag, input logic we, input logic [63:0] addr,
                       input logic [63:0] wdata, input logic [7:0] mask,
                       input logic [63:0] exp_rdata, input logic exp_err);
        issue(tag, we, addr, wdata, mask, 1'b0);
        finish_rsp(tag, exp_rdata, exp_err, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int highs;
        #1 rst = 1'b0;
        @(negedge clk);
        do_reset("por");

        txn("st full", 1'b1, 64'h8000_0008, 64'h1122_3344_5566_7788, 8'hFF, 64'd0, 1'b0);
        txn("ld full", 1'b0, 64'h8000_0008, 64'd0, 8'h00, 64'h1122_3344_5566_7788, 1'b0);
        txn("st part", 1'b1, 64'h8000_0008, 64'hAAAA_AAAA_BBBB_BBBB, 8'h0F, 64'd0, 1'b0);
        txn("ld part", 1'b0, 64'h8000_0008, 64'd0, 8'h00, 64'h1122_3344_BBBB_BBBB, 1'b0);
        txn("st w0", 1'b1, 64'h8000_0000, 64'hCAFE_F00D_1234_5678, 8'hFF, 64'd0, 1'b0);
        txn("st last", 1'b1, 64'h8000_1FF8, 64'h0F0E_0D0C_0B0A_0908, 8'hFF, 64'd0, 1'b0);
        txn("ld last", 1'b0, 64'h8000_1FF8, 64'd0, 8'h00, 64'h0F0E_0D0C_0B0A_0908, 1'b0);
        txn("st mask0", 1'b1, 64'h8000_0008, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 64'd0, 1'b0);
        txn("ld mask0", 1'b0, 64'h8000_0008, 64'd0, 8'h00, 64'h1122_3344_BBBB_BBBB, 1'b0);

        txn("ld below", 1'b0, 64'h7FFF_FFF8, 64'd0, 8'h00, 64'd0, 1'b1);
        txn("ld misal", 1'b0, 64'h8000_0004, 64'd0, 8'h00, 64'd0, 1'b1);
        txn("st above", 1'b1, 64'h8000_2000, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF, 64'd0, 1'b1);
        txn("st misal", 1'b1, 64'h8000_000C, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF, 64'd0, 1'b1);
        txn("ld w0 kept", 1'b0, 64'h8000_0000, 64'd0, 8'h00, 64'hCAFE_F00D_1234_5678, 1'b0);
        txn("ld w1 kept", 1'b0, 64'h8000_0008, 64'd0, 8'h00, 64'h1122_3344_BBBB_BBBB, 1'b0);

        // Backpressure with the next request held on the bus throughout.
        issue("bp", 1'b0, 64'h8000_0000, 64'd0, 8'h00, 1'b1);
        finish_rsp("bp", 64'hCAFE_F00D_1234_5678, 1'b0, 5);
        req_addr = 64'h8000_1FF8;
        @(posedge clk);
        @(negedge clk);
        check("bp next accepted", 64'(o_rdy), 64'd0);
        check("bp next not resp", 64'(o_vld), 64'd0);
        req_valid = 1'b0;
        finish_rsp("bp next", 64'h0F0E_0D0C_0B0A_0908, 1'b0, 0);

        txn("st prior", 1'b1, 64'h8000_0010, 64'h5555_6666_7777_8888, 8'hFF, 64'd0, 1'b0);
        issue("st drop", 1'b1, 64'h8000_0010, 64'h9999_9999_9999_9999, 8'hFF, 1'b0);
        check("st drop in wait", 64'(o_vld), 64'd0);
        do_reset("wait");
        txn("ld prior", 1'b0, 64'h8000_0010, 64'd0, 8'h00, 64'h5555_6666_7777_8888, 1'b0);

        issue("ld drop", 1'b0, 64'h8000_0008, 64'd0, 8'h00, 1'b0);
        wait_vld(n);
        check("ld drop resp", o_rdata, 64'h1122_3344_BBBB_BBBB);
        do_reset("resp");
        issue("err drop", 1'b0, 64'h8000_0004, 64'd0, 8'h00, 1'b0);
        wait_vld(n);
        check("err drop resp", 64'(o_err), 64'd1);
        do_reset("resp err");
        txn("ld after rst", 1'b0, 64'h8000_0008, 64'd0, 8'h00, 64'h1122_3344_BBBB_BBBB, 1'b0);

        sel = 1'b1;
        txn("l0 st", 1'b1, 64'h8000_0018, 64'h0102_0304_0506_0708, 8'hFF, 64'd0, 1'b0);
        txn("l0 ld", 1'b0, 64'h8000_0018, 64'd0, 8'h00, 64'h0102_0304_0506_0708, 1'b0);
        txn("l0 fault", 1'b0, 64'h8000_2008, 64'd0, 8'h00, 64'd0, 1'b1);

        // Back-to-back loads: one response every other cycle.
        req_we = 1'b0; req_addr = 64'h8000_0018; req_valid = 1'b1; rsp_ready = 1'b1;
        highs = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (o_vld) highs++;
        end
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        check("l0 b2b responses", 64'(highs), 64'd4);
        check("l0 b2b idle", 64'(o_rdy), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
